// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter feeding two requesters into one banked memory port.
// Each bank carries a busy counter that enforces per-bank spacing after a grant; read
// grants are tagged through a pipeline so returning data is steered to the right requester.
module mem_port_arbiter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned NUM_BANK      = 4,
  parameter int unsigned WRITE_LATENCY = 4,
  parameter int unsigned READ_LATENCY  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_a,
  input  logic                  i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0]      i_din_a,
  input  logic                  i_req_b,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0]      i_din_b,
  output logic                  o_gnt_a,
  output logic                  o_gnt_b,
  output logic                  o_rsp_valid_a,
  output logic [WIDTH-1:0]      o_rsp_dout_a,
  output logic                  o_rsp_valid_b,
  output logic [WIDTH-1:0]      o_rsp_dout_b,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_din,
  input  logic [WIDTH-1:0]      i_mem_dout
);

  localparam int unsigned BANK_BITS = $clog2(NUM_BANK);
  localparam int unsigned MAX_LAT   = (WRITE_LATENCY > READ_LATENCY) ? WRITE_LATENCY
                                                                      : READ_LATENCY;
  localparam int unsigned CNT_W     = $clog2(MAX_LAT) + 1;
  localparam int unsigned TAG_DEPTH = READ_LATENCY + 1;

  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);

  // Round-robin pointer and tag-ID encodings
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;
  localparam logic ID_A  = 1'b0;
  localparam logic ID_B  = 1'b1;

  logic [CNT_W-1:0]      busy_q [NUM_BANK];
  logic                  rr_q;
  logic [TAG_DEPTH-1:0]  tag_vld_q;
  logic [TAG_DEPTH-1:0]  tag_id_q;

  logic [BANK_BITS-1:0]  bank_a;
  logic [BANK_BITS-1:0]  bank_b;
  logic [BANK_BITS-1:0]  sel_bank;
  logic                  elig_a;
  logic                  elig_b;
  logic                  any_gnt;
  logic                  rd_gnt;
  logic                  sel_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_din;
  logic                  rsp_a;
  logic                  rsp_b;

  // Bank is taken from the top address bits
  assign bank_a = i_addr_a[ADDR_WIDTH-1 -: BANK_BITS];
  assign bank_b = i_addr_b[ADDR_WIDTH-1 -: BANK_BITS];

  // Eligibility, round-robin choice and selection of the winning request
  always_comb begin
    elig_a   = i_req_a && (busy_q[bank_a] == '0);
    elig_b   = i_req_b && (busy_q[bank_b] == '0);
    o_gnt_a  = !i_rst && elig_a && (!elig_b || (rr_q == PTR_A));
    o_gnt_b  = !i_rst && elig_b && (!elig_a || (rr_q == PTR_B));
    any_gnt  = o_gnt_a || o_gnt_b;
    sel_id   = o_gnt_b ? ID_B : ID_A;
    sel_we   = o_gnt_b ? i_we_b   : i_we_a;
    sel_addr = o_gnt_b ? i_addr_b : i_addr_a;
    sel_din  = o_gnt_b ? i_din_b  : i_din_a;
    sel_bank = o_gnt_b ? bank_b   : bank_a;
    rd_gnt   = any_gnt && !sel_we;
  end

  // Per-bank busy counters: load on grant, otherwise count down to zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_BANK; i++) busy_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BANK; i++) begin
        if (any_gnt && (sel_bank == BANK_BITS'(i))) begin
          busy_q[i] <= sel_we ? WR_LOAD : RD_LOAD;
        end else if (busy_q[i] != '0) begin
          busy_q[i] <= busy_q[i] - 1'b1;
        end
      end
    end
  end

  // Round-robin pointer moves to the requester that lost (or did not ask)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_q <= PTR_A;
    end else if (o_gnt_a) begin
      rr_q <= PTR_B;
    end else if (o_gnt_b) begin
      rr_q <= PTR_A;
    end
  end

  // Registered memory command; address and data hold when idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_en   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_din  <= '0;
    end else begin
      o_mem_en <= any_gnt;
      o_mem_we <= any_gnt && sel_we;
      if (any_gnt) begin
        o_mem_addr <= sel_addr;
        o_mem_din  <= sel_din;
      end
    end
  end

  // Read tag pipeline; last stage lines up with valid memory data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[TAG_DEPTH-2:0], rd_gnt};
      tag_id_q  <= {tag_id_q[TAG_DEPTH-2:0], sel_id};
    end
  end

  assign rsp_a = tag_vld_q[TAG_DEPTH-1] && (tag_id_q[TAG_DEPTH-1] == ID_A);
  assign rsp_b = tag_vld_q[TAG_DEPTH-1] && (tag_id_q[TAG_DEPTH-1] == ID_B);

  // Capture returning read data into the tagged requester's response register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_valid_a <= 1'b0;
      o_rsp_valid_b <= 1'b0;
      o_rsp_dout_a  <= '0;
      o_rsp_dout_b  <= '0;
    end else begin
      o_rsp_valid_a <= rsp_a;
      o_rsp_valid_b <= rsp_b;
      if (rsp_a) o_rsp_dout_a <= i_mem_dout;
      if (rsp_b) o_rsp_dout_b <= i_mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a timestamp-based reference model.
module tb_mem_port_arbiter;

  localparam int W  = 8;
  localparam int AW = 5;
  localparam int NB = 4;
  localparam int WL = 4;
  localparam int RL = 5;

  typedef struct {
    int          cyc;
    bit          id;
    logic [W-1:0] data;
  } rsp_t;

  logic          clk, rst;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  din_a, din_b;
  logic          gnt_a, gnt_b, vld_a, vld_b;
  logic [W-1:0]  dout_a, dout_b;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_din, mem_dout;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(
    .WIDTH(W), .ADDR_WIDTH(AW), .NUM_BANK(NB), .WRITE_LATENCY(WL), .READ_LATENCY(RL)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_a(req_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
    .i_req_b(req_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
    .o_gnt_a(gnt_a), .o_gnt_b(gnt_b),
    .o_rsp_valid_a(vld_a), .o_rsp_dout_a(dout_a),
    .o_rsp_valid_b(vld_b), .o_rsp_dout_b(dout_b),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data sampled when the read is issued, presented RL cycles later.
  logic [W-1:0]  mem [1 << AW];
  logic [W-1:0]  rd_pipe [RL + 1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [W-1:0]  pre_data = '0;

  always @(negedge clk) begin
    if (pre_we) mem[pre_addr] = pre_data;
    for (int k = RL; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
    if (mem_en && !mem_we) rd_pipe[0] = mem[mem_addr];
    else rd_pipe[0] = W'($urandom);
    if (mem_en && mem_we) mem[mem_addr] = mem_din;
    mem_dout = rd_pipe[RL];
  end

  function automatic int bank_of(input logic [AW-1:0] a);
    return int'(a) / ((1 << AW) / NB);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Writes one memory word via the model; ends aligned to posedge+1
  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    #1 pre_we = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    req_a = 1; req_b = 1; addr_b = 5'h09;
    rst = 1'b1;
    #1;
    n_checks++; if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {gnt_a, gnt_b}); else n_pass++;
    n_checks++; if ({mem_en, mem_we} !== 2'b00) $display("FAIL reset_mem_ctl: got %b want 00", {mem_en, mem_we}); else n_pass++;
    n_checks++; if ({mem_addr, mem_din} !== '0) $display("FAIL reset_mem_data: got %h want 0", {mem_addr, mem_din}); else n_pass++;
    n_checks++; if ({vld_a, vld_b} !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", {vld_a, vld_b}); else n_pass++;
    n_checks++; if ({dout_a, dout_b} !== '0) $display("FAIL reset_rsp_dout: got %h want 0", {dout_a, dout_b}); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL reset_gnt_held: got %b want 00", {gnt_a, gnt_b}); else n_pass++;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_no_cmd: got %b want 0", mem_en); else n_pass++;
    next_cycle();
  endtask

  task automatic test_single_read();
    do_reset();
    preload(5'h03, 8'hA5);
    req_a = 1; we_a = 0; addr_a = 5'h03;
    @(negedge clk);
    n_checks++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL single_gnt: got %b want 10", {gnt_a, gnt_b}); else n_pass++;
    next_cycle();
    req_a = 0;
    @(negedge clk);
    n_checks++; if ({mem_en, mem_we} !== 2'b10) $display("FAIL single_cmd: got %b want 10", {mem_en, mem_we}); else n_pass++;
    n_checks++; if (mem_addr !== 5'h03) $display("FAIL single_addr: got %h want 03", mem_addr); else n_pass++;
    for (int k = 2; k <= 8; k++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (vld_a !== (k == 7)) $display("FAIL single_vld_a cyc %0d: got %b want %b", k, vld_a, k == 7); else n_pass++;
      n_checks++; if (vld_b !== 1'b0) $display("FAIL single_vld_b cyc %0d: got %b want 0", k, vld_b); else n_pass++;
      if (k == 7) begin
        n_checks++; if (dout_a !== 8'hA5) $display("FAIL single_dout: got %h want a5", dout_a); else n_pass++;
      end
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    do_reset();
    req_a = 1; we_a = 1; addr_a = 5'h01; din_a = 8'h11;
    req_b = 1; we_b = 1; addr_b = 5'h09; din_b = 8'h22;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      n_checks++; if (gnt_a !== (k % 4 == 0)) $display("FAIL alt_gnt_a cyc %0d: got %b want %b", k, gnt_a, k % 4 == 0); else n_pass++;
      n_checks++; if (gnt_b !== (k % 4 == 1)) $display("FAIL alt_gnt_b cyc %0d: got %b want %b", k, gnt_b, k % 4 == 1); else n_pass++;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_same_bank();
    do_reset();
    req_a = 1; we_a = 1; addr_a = 5'h00; din_a = 8'h3C;
    @(negedge clk);
    n_checks++; if (gnt_a !== 1'b1) $display("FAIL sb_first_gnt: got %b want 1", gnt_a); else n_pass++;
    next_cycle();
    req_a = 0; req_b = 1; we_b = 0; addr_b = 5'h02;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (gnt_b !== (k == 4)) $display("FAIL sb_gnt_b cyc %0d: got %b want %b", k, gnt_b, k == 4); else n_pass++;
      next_cycle();
    end
    req_b = 0; req_a = 1; we_a = 0; addr_a = 5'h05;
    for (int k = 5; k <= 9; k++) begin
      @(negedge clk);
      n_checks++; if (gnt_a !== (k == 9)) $display("FAIL sb_gnt_a cyc %0d: got %b want %b", k, gnt_a, k == 9); else n_pass++;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    do_reset();
    req_a = 1; we_a = 1; addr_a = 5'h00; din_a = 8'h01;
    @(negedge clk);
    n_checks++; if (gnt_a !== 1'b1) $display("FAIL byp_first_gnt: got %b want 1", gnt_a); else n_pass++;
    next_cycle();
    addr_a = 5'h04; din_a = 8'h02;
    req_b = 1; we_b = 1; addr_b = 5'h18; din_b = 8'h03;
    @(negedge clk);
    n_checks++; if ({gnt_a, gnt_b} !== 2'b01) $display("FAIL byp_gnt: got %b want 01", {gnt_a, gnt_b}); else n_pass++;
    next_cycle();
    req_b = 0;
    @(negedge clk);
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_din} !== {2'b11, 5'h18, 8'h03}) $display("FAIL byp_cmd: got %h want %h", {mem_en, mem_we, mem_addr, mem_din}, {2'b11, 5'h18, 8'h03}); else n_pass++;
    for (int k = 2; k <= 4; k++) begin
      if (k > 2) @(negedge clk);
      n_checks++; if (gnt_a !== (k == 4)) $display("FAIL byp_gnt_a cyc %0d: got %b want %b", k, gnt_a, k == 4); else n_pass++;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_read_order();
    logic [W-1:0] d0, d1, d2;
    d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom);
    do_reset();
    preload(5'h02, d0);
    preload(5'h0A, d1);
    preload(5'h12, d2);
    req_a = 1; we_a = 0; addr_a = 5'h02;
    @(negedge clk);
    n_checks++; if (gnt_a !== 1'b1) $display("FAIL ord_gnt0: got %b want 1", gnt_a); else n_pass++;
    next_cycle();
    req_a = 0; req_b = 1; we_b = 0; addr_b = 5'h0A;
    @(negedge clk);
    n_checks++; if (gnt_b !== 1'b1) $display("FAIL ord_gnt1: got %b want 1", gnt_b); else n_pass++;
    next_cycle();
    req_b = 0; req_a = 1; addr_a = 5'h12;
    @(negedge clk);
    n_checks++; if (gnt_a !== 1'b1) $display("FAIL ord_gnt2: got %b want 1", gnt_a); else n_pass++;
    next_cycle();
    req_a = 0;
    for (int k = 3; k <= 11; k++) begin
      @(negedge clk);
      n_checks++; if (vld_a !== (k == 7 || k == 9)) $display("FAIL ord_vld_a cyc %0d: got %b", k, vld_a); else n_pass++;
      n_checks++; if (vld_b !== (k == 8)) $display("FAIL ord_vld_b cyc %0d: got %b", k, vld_b); else n_pass++;
      if (k == 7 || k == 8) begin
        n_checks++; if (dout_a !== d0) $display("FAIL ord_dout_a0 cyc %0d: got %h want %h", k, dout_a, d0); else n_pass++;
      end
      if (k == 8) begin
        n_checks++; if (dout_b !== d1) $display("FAIL ord_dout_b: got %h want %h", dout_b, d1); else n_pass++;
      end
      if (k == 9) begin
        n_checks++; if (dout_a !== d2) $display("FAIL ord_dout_a2: got %h want %h", dout_a, d2); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req_a = 1; we_a = 0; addr_a = 5'h07;
    @(negedge clk);
    n_checks++; if (gnt_a !== 1'b1) $display("FAIL rmr_gnt: got %b want 1", gnt_a); else n_pass++;
    next_cycle();
    req_a = 0;
    next_cycle();
    #1 rst = 1'b1;
    req_a = 1; we_a = 1; addr_a = 5'h1F; din_a = 8'h5A;
    #1;
    n_checks++; if ({gnt_a, mem_en, mem_we, vld_a, vld_b} !== 5'b0) $display("FAIL rmr_ctl_zero: got %b want 00000", {gnt_a, mem_en, mem_we, vld_a, vld_b}); else n_pass++;
    n_checks++; if ({mem_addr, mem_din, dout_a, dout_b} !== '0) $display("FAIL rmr_data_zero: got %h want 0", {mem_addr, mem_din, dout_a, dout_b}); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (gnt_a !== 1'b1) $display("FAIL rmr_first_gnt: got %b want 1", gnt_a); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 5'h1F}) $display("FAIL rmr_cmd: got %h want %h", {mem_en, mem_we, mem_addr}, {2'b11, 5'h1F}); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if ({vld_a, vld_b} !== 2'b00) $display("FAIL rmr_no_rsp cyc %0d: got %b want 00", k, {vld_a, vld_b}); else n_pass++;
    end
    next_cycle();
  endtask

  // Randomized traffic against a model built on per-bank "free from cycle" timestamps
  task automatic test_random();
    logic [W-1:0]  shadow [1 << AW];
    int            free_at [NB];
    bit            favor_b, pa, pb, ea, eb, ga, gb, exp_en, exp_we, exp_va, exp_vb, id, we;
    logic [AW-1:0] exp_addr, addr;
    logic [W-1:0]  exp_din, last_da, last_db, din, v;
    rsp_t          rq[$];
    rsp_t          r;
    do_reset();
    for (int a = 0; a < (1 << AW); a++) begin
      v = W'($urandom);
      shadow[a] = v;
      preload(AW'(a), v);
    end
    for (int b = 0; b < NB; b++) free_at[b] = 0;
    favor_b = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_din = '0;
    last_da = '0; last_db = '0; pa = 0; pb = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1; we_a = 1'($urandom); addr_a = AW'($urandom); din_a = W'($urandom);
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1; we_b = 1'($urandom); addr_b = AW'($urandom); din_b = W'($urandom);
      end
      req_a = pa; req_b = pb;
      @(negedge clk);
      ea = pa && (c >= free_at[bank_of(addr_a)]);
      eb = pb && (c >= free_at[bank_of(addr_b)]);
      ga = ea && (!eb || !favor_b);
      gb = eb && !ga;
      n_checks++; if ({gnt_a, gnt_b} !== {ga, gb}) $display("FAIL rnd_gnt cyc %0d: got %b want %b", c, {gnt_a, gnt_b}, {ga, gb}); else n_pass++;
      n_checks++; if ({mem_en, mem_we, mem_addr, mem_din} !== {exp_en, exp_we, exp_addr, exp_din}) $display("FAIL rnd_cmd cyc %0d: got %h want %h", c, {mem_en, mem_we, mem_addr, mem_din}, {exp_en, exp_we, exp_addr, exp_din}); else n_pass++;
      exp_va = 0; exp_vb = 0;
      if (rq.size() > 0 && rq[0].cyc == c) begin
        r = rq.pop_front();
        if (r.id) begin exp_vb = 1; last_db = r.data; end
        else begin exp_va = 1; last_da = r.data; end
      end
      n_checks++; if ({vld_a, vld_b} !== {exp_va, exp_vb}) $display("FAIL rnd_vld cyc %0d: got %b want %b", c, {vld_a, vld_b}, {exp_va, exp_vb}); else n_pass++;
      n_checks++; if ({dout_a, dout_b} !== {last_da, last_db}) $display("FAIL rnd_dout cyc %0d: got %h want %h", c, {dout_a, dout_b}, {last_da, last_db}); else n_pass++;
      if (ga || gb) begin
        id   = gb;
        we   = gb ? we_b : we_a;
        addr = gb ? addr_b : addr_a;
        din  = gb ? din_b : din_a;
        free_at[bank_of(addr)] = c + (we ? WL : RL);
        favor_b = ga;
        exp_en = 1; exp_we = we; exp_addr = addr; exp_din = din;
        if (we) begin
          shadow[addr] = din;
        end else begin
          r.cyc = c + 2 + RL; r.id = id; r.data = shadow[addr];
          rq.push_back(r);
        end
        if (ga) pa = 0;
        else pb = 0;
      end else begin
        exp_en = 0; exp_we = 0;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_same_bank();
    test_bypass();
    test_read_order();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 8, data width
- ADDR_WIDTH, 5, address width
- NUM_BANK, 4, number of banks (power of 2, at least 2)
- WRITE_LATENCY, 4, minimum cycles between the grant of a write and the next grant to the same bank
- READ_LATENCY, 5, cycles from o_mem_en of a read to valid i_mem_dout; also the same-bank spacing after a read grant
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, the only clock
- i_rst, in, 1, asynchronous active-high reset
- i_req_a / i_req_b, in, 1, request valid for requester A / B
- i_we_a / i_we_b, in, 1, 1 = write, 0 = read
- i_addr_a / i_addr_b, in, ADDR_WIDTH, request address
- i_din_a / i_din_b, in, WIDTH, write data
- o_gnt_a / o_gnt_b, out, 1, request accepted this cycle (combinational)
- o_rsp_valid_a / o_rsp_valid_b, out, 1, read data valid (registered)
- o_rsp_dout_a / o_rsp_dout_b, out, WIDTH, read data (registered)
- o_mem_en, o_mem_we, out, 1 each, memory command (registered)
- o_mem_addr, out, ADDR_WIDTH, memory address (registered)
- o_mem_din, out, WIDTH, memory write data (registered)
- i_mem_dout, in, WIDTH, memory read data
REQ-003 Clocking SHALL be a single clock, i_clk; reset SHALL be i_rst, asynchronous and active-high.

Function
REQ-004 Bank of an address SHALL be addr[ADDR_WIDTH-1 -: log2(NUM_BANK)] (the top bits).
REQ-005 Each bank SHALL have a busy counter, width clog2(max latency)+1, reset value 0.
REQ-006 Requester X SHALL be eligible when i_req_x=1 and the busy counter of its bank is 0.
REQ-007 At most one grant SHALL be issued per cycle; o_gnt_a and o_gnt_b SHALL never be high together.
REQ-008 Only one requester eligible: that requester SHALL be granted.
REQ-009 Both eligible: the requester selected by the round-robin pointer SHALL be granted.
REQ-010 Round-robin pointer: reset value = A; after any grant it SHALL point to the non-granted requester.
REQ-011 A requester SHALL hold req, we, addr and din stable until it is granted; a transfer occurs in a cycle where req and gnt are both high.
REQ-012 Grant in cycle T SHALL load the busy counter of the granted bank with LAT-1 at the end of T (LAT = WRITE_LATENCY for a write, READ_LATENCY for a read). A nonzero counter SHALL decrement by 1 each cycle. Earliest next grant to the same bank is therefore T+LAT.
REQ-013 Grant in cycle T SHALL drive o_mem_en=1 in cycle T+1, with o_mem_we/o_mem_addr/o_mem_din equal to the granted request. With no grant, o_mem_en=0 and o_mem_we=0; addr and din SHALL hold their last values.
REQ-014 Each read grant SHALL enter a READ_LATENCY+1-deep tag pipeline carrying valid and requester ID. At the end of cycle T+1+READ_LATENCY, i_mem_dout SHALL be captured into o_rsp_dout_x. o_rsp_valid_x SHALL be 1 for exactly cycle T+2+READ_LATENCY.
REQ-015 Write grants SHALL produce no response.
REQ-016 Reads SHALL be returned in grant order. Back-to-back reads to different banks SHALL give back-to-back responses. o_rsp_dout_x SHALL hold its value when o_rsp_valid_x=0.
REQ-017 A request whose bank is busy SHALL wait without blocking the other requester if the other requester's bank is free.

Reset
REQ-018 While i_rst=1, asynchronously: all busy counters = 0; tag pipeline cleared; pointer = A; o_mem_en = o_mem_we = 0; o_mem_addr = o_mem_din = 0; o_rsp_valid_a/b = 0; o_rsp_dout_a/b = 0. o_gnt_a and o_gnt_b SHALL be forced to 0 while i_rst=1.
REQ-019 Reads in flight when reset asserts SHALL be dropped and never produce a response. The first grant after reset release SHALL be possible in the first cycle in which i_rst=0.

Verification
REQ-020 Single read: A reads addr 5'h03 at T; memory returns 8'hA5 at T+6 -> o_mem_en at T+1 with addr 5'h03; o_rsp_valid_a=1 with dout 8'hA5 at T+7; o_rsp_valid_b stays 0.
REQ-021 Simultaneous requests, different banks: A writes 5'h01, B writes 5'h09, both from reset -> A granted at T, B at T+1; with both held continuously afterwards, grants alternate A,B,A,B.
REQ-022 Same-bank spacing: A writes 5'h00 at T, then B reads 5'h02 (bank 0) immediately -> B not granted before T+4. Then A reads 5'h05 right after B's grant -> A not granted before B's grant + 5.
REQ-023 Busy-bank bypass: bank 0 busy from an A write; B requests bank 3 -> B granted the next cycle while A's new bank-0 request waits.
REQ-024 Read ordering: A reads bank 0, B reads bank 1, A reads bank 2 on consecutive cycles -> responses A, B, A on consecutive cycles, each carrying the data memory presented for that read.
REQ-025 Reset mid-read: assert i_rst 2 cycles after a read grant -> all outputs 0 immediately; no o_rsp_valid pulse after release; a new request is granted in the first cycle after release.
